laplace_window_gen: RTL and testbench

Streaming neighbourhood generator feeding the Laplace filter datapath. It accepts a raster-order 8-bit pixel stream of one ROWS×COLS image and emits, for every interior pixel, the five-pixel cross neighbourhood b/d/e/f/h. These ports connect directly to the filter kernels' b/d/e/f/h inputs. It replaces the bench-side image indexing with hardware line buffers, so the filter kernels run on a live stream with valid/ready flow control.

---
 rtl/laplace_pkg.sv | 19 +
 rtl/laplace_window_gen_if.sv | 52 +++++
 rtl/laplace_line_buffer.sv | 26 ++
 rtl/laplace_window_gen.sv | 156 +++++++++++++++
 tb/tb_laplace_window_gen.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/laplace_pkg.sv
// laplace_pkg: shared constants and types for the Laplace window generator.
// Holds the default pixel width, the default image geometry and the interior
// window count used by the generator and its surroundings.
package laplace_pkg;

    localparam int PIX_W_DEF = 8;
    typedef logic [PIX_W_DEF-1:0] pixel_t;

    localparam int IMG_ROWS = 512;
    localparam int IMG_COLS = 512;

    // Number of interior windows (centres that have all four neighbours).
    function automatic int win_count(input int rows, input int cols);
        return (rows - 2) * (cols - 2);
    endfunction

    localparam int WIN_COUNT = (IMG_ROWS - 2) * (IMG_COLS - 2);

endpackage

// File: rtl/laplace_window_gen_if.sv
// laplace_window_gen_if: pixel input stream and window output stream of the
// Laplace window generator. Optional macro LAPLACE_WIN_COORD_EN adds the
// out_row/out_col centre-coordinate outputs.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. The producer keeps data stable and valid asserted until the
// transfer; ready may be combinational from the consumer's state. On the
// input side in_ready = !out_valid || out_ready (no skid buffer).
interface laplace_window_gen_if
    import laplace_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int ROWS  = IMG_ROWS,
    parameter int COLS  = IMG_COLS
);
    logic [PIX_W-1:0] in_pixel;
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] b;
    logic [PIX_W-1:0] d;
    logic [PIX_W-1:0] e;
    logic [PIX_W-1:0] f;
    logic [PIX_W-1:0] h;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
`ifdef LAPLACE_WIN_COORD_EN
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    logic [RW-1:0]    out_row;
    logic [CW-1:0]    out_col;
`endif

    // Generator side.
    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, b, d, e, f, h, out_valid, out_last
`ifdef LAPLACE_WIN_COORD_EN
        , out_row, out_col
`endif
    );

    // Pixel source / window consumer side.
    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, b, d, e, f, h, out_valid, out_last
`ifdef LAPLACE_WIN_COORD_EN
        , out_row, out_col
`endif
    );

endinterface

// File: rtl/laplace_line_buffer.sv
// laplace_line_buffer: one image row of pixels. Combinational read at addr_i,
// write at the same address on the clock edge when we_i is set, so a single
// access reads the old value before it is overwritten. Contents are not reset.
module laplace_line_buffer #(
    parameter int DEPTH = 512,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [PIX_W-1:0]         wdata_i,
    output logic [PIX_W-1:0]         rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Row storage: overwrite the addressed entry on each accepted pixel.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/laplace_window_gen.sv
// laplace_window_gen: turns a raster-order pixel stream into the five-pixel
// cross neighbourhood (b above, d left, e centre, f right, h below) for every
// interior pixel, using two line buffers and a few tap registers.
// Optional macro LAPLACE_WIN_COORD_EN adds out_row/out_col centre coordinates.
//
// Accepting pixel (r, c) with r >= 2 and c >= 2 completes the window centred
// at (r-1, c-1): lb0 read gives (r-1, c), lb1 read gives (r-2, c), and the
// taps hold the one/two-accept-old versions of those streams.
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int COLS  = IMG_COLS,
    parameter int ROWS  = IMG_ROWS,
    parameter int PIX_W = PIX_W_DEF
) (
    input logic                 clk,
    input logic                 rst,
    laplace_window_gen_if.slave win
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] TWO_COL  = CW'(2);
    localparam logic [RW-1:0] TWO_ROW  = RW'(2);

    logic [CW-1:0]    in_col_q;
    logic [RW-1:0]    in_row_q;

    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    logic [PIX_W-1:0] h_d_q;
    logic [PIX_W-1:0] m1_q;
    logic [PIX_W-1:0] m2_q;
    logic [PIX_W-1:0] t1_q;

    logic [PIX_W-1:0] b_q;
    logic [PIX_W-1:0] d_q;
    logic [PIX_W-1:0] e_q;
    logic [PIX_W-1:0] f_q;
    logic [PIX_W-1:0] h_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic             accept;
    logic             win_hit;
    logic             last_hit;

    // A new pixel is taken whenever the output register is free or draining.
    assign win.in_ready = !out_valid_q || win.out_ready;
    assign accept       = win.in_valid && win.in_ready && !rst;
    assign win_hit      = accept && (in_row_q >= TWO_ROW) && (in_col_q >= TWO_COL);
    assign last_hit     = (in_row_q == LAST_ROW) && (in_col_q == LAST_COL);

    // lb0 keeps the previous row; lb1 receives whatever lb0 is displacing.
    laplace_line_buffer #(.DEPTH(COLS), .PIX_W(PIX_W)) u_lb0 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (in_col_q),
        .wdata_i (win.in_pixel),
        .rdata_o (lb0_rd)
    );

    laplace_line_buffer #(.DEPTH(COLS), .PIX_W(PIX_W)) u_lb1 (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (in_col_q),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    // Raster position of the next pixel to be accepted; frames run back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_col_q <= '0;
            in_row_q <= '0;
        end else if (accept) begin
            if (in_col_q == LAST_COL) begin
                in_col_q <= '0;
                in_row_q <= (in_row_q == LAST_ROW) ? '0 : in_row_q + RW'(1);
            end else begin
                in_col_q <= in_col_q + CW'(1);
            end
        end
    end

    // Tap delays; they run across row boundaries, stale data is masked by c >= 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_d_q <= '0;
            m1_q  <= '0;
            m2_q  <= '0;
            t1_q  <= '0;
        end else if (accept) begin
            h_d_q <= win.in_pixel;
            m1_q  <= lb0_rd;
            m2_q  <= m1_q;
            t1_q  <= lb1_rd;
        end
    end

    // Output window register: load on a qualifying accept, drop once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            f_q         <= '0;
            h_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (win_hit) begin
            b_q         <= t1_q;
            d_q         <= m2_q;
            e_q         <= m1_q;
            f_q         <= lb0_rd;
            h_q         <= h_d_q;
            out_valid_q <= 1'b1;
            out_last_q  <= last_hit;
        end else if (win.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign win.b         = b_q;
    assign win.d         = d_q;
    assign win.e         = e_q;
    assign win.f         = f_q;
    assign win.h         = h_q;
    assign win.out_valid = out_valid_q;
    assign win.out_last  = out_last_q;

`ifdef LAPLACE_WIN_COORD_EN
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // Centre coordinates travel with the window and hold with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (win_hit) begin
            out_row_q <= in_row_q - RW'(1);
            out_col_q <= in_col_q - CW'(1);
        end
    end

    assign win.out_row = out_row_q;
    assign win.out_col = out_col_q;
`endif

endmodule

// File: tb/tb_laplace_window_gen.sv
// tb_laplace_window_gen: 4x4 frames through laplace_window_gen. Expected
// windows come from indexing the frame array directly; a monitor pops them
// on every output handshake and also checks that a stalled window holds.
module tb_laplace_window_gen;
    import laplace_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int PW   = 8;
    localparam int NPIX = ROWS * COLS;
    localparam int EW   = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    laplace_window_gen_if #(.PIX_W(PW), .ROWS(ROWS), .COLS(COLS)) bus ();

    laplace_window_gen #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .win (bus)
    );

    // ---------------- scoreboard state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int win_seen  = 0;
    int last_seen = 0;
    logic [EW-1:0] exp_q[$];
    logic [PW-1:0] frame [NPIX];

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Window layout: {row, col, 6'b0, valid, last, b, d, e, f, h}
    function automatic logic [EW-1:0] pack_win(input int r, input int c, input logic vld,
                                               input logic lst, input logic [PW-1:0] pb,
                                               input logic [PW-1:0] pd, input logic [PW-1:0] pe,
                                               input logic [PW-1:0] pf, input logic [PW-1:0] ph);
        logic [7:0] rr = 8'(r);
        logic [7:0] cc = 8'(c);
        return {rr, cc, 6'd0, vld, lst, pb, pd, pe, pf, ph};
    endfunction

    function automatic logic [EW-1:0] obs_win();
        int rr = 0;
        int cc = 0;
`ifdef LAPLACE_WIN_COORD_EN
        rr = int'(bus.out_row);
        cc = int'(bus.out_col);
`endif
        return pack_win(rr, cc, bus.out_valid, bus.out_last, bus.b, bus.d, bus.e, bus.f, bus.h);
    endfunction

    // Reference: every interior centre in raster order, neighbours by indexing.
    task automatic model_frame();
        for (int r = 1; r <= ROWS - 2; r++) begin
            for (int c = 1; c <= COLS - 2; c++) begin
                int rr = 0;
                int cc = 0;
`ifdef LAPLACE_WIN_COORD_EN
                rr = r;
                cc = c;
`endif
                exp_q.push_back(pack_win(rr, cc, 1'b1, (r == ROWS - 2) && (c == COLS - 2),
                                         frame[(r - 1) * COLS + c], frame[r * COLS + c - 1],
                                         frame[r * COLS + c], frame[r * COLS + c + 1],
                                         frame[(r + 1) * COLS + c]));
            end
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) frame[i] = PW'(i);  // 4r + c
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) frame[i] = PW'($urandom_range(0, 255));
    endtask

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_obs   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("hold_while_stalled", obs_win(), prev_obs);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_window: observed %h expected none", obs_win());
                end else begin
                    check("window", obs_win(), exp_q.pop_front());
                end
                win_seen++;
                if (bus.out_last) last_seen++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_obs   = obs_win();
        end
    end

    // ---------------- driver tasks ----------------
    // Sends frame[] (or its first `limit` pixels) with random gaps; optionally
    // holds out_ready low for stall_cycles once the first window appears.
    task automatic run_frame(input int in_gap, input int out_gap, input int stall_cycles,
                             input int limit);
        int  idx     = 0;
        int  budget  = 0;
        bit  stalled = 1'b0;
        while (idx < limit && budget < 2000) begin
            if (stall_cycles > 0 && !stalled && bus.out_valid) begin
                stalled       = 1'b1;
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_pixel  = frame[idx];
                for (int k = 0; k < stall_cycles; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", EW'(bus.in_ready), EW'(0));
                    check("stall_bdefh", EW'({bus.b, bus.d, bus.e, bus.f, bus.h}),
                          EW'(40'h01_04_05_06_09));
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid  = ($urandom_range(0, 99) >= in_gap);
            bus.in_pixel  = frame[idx];
            bus.out_ready = ($urandom_range(0, 99) >= out_gap);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk);
            #1;
            budget++;
        end
        if (idx < limit) begin
            total_cnt++;
            $display("FAIL send_timeout: observed %0d accepts expected %0d", idx, limit);
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", EW'(exp_q.size()), EW'(0));
    endtask

    // Reset with in_valid high; checks outputs idle during and right after it.
    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_pixel = 8'hAA;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", EW'(bus.out_valid), EW'(0));
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", EW'(bus.in_ready), EW'(1));
        check("post_rst_outputs", obs_win(), EW'(0));
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w0;
        int l0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Ramp frame, continuous flow.
        w0 = win_seen; l0 = last_seen;
        fill_ramp();
        model_frame();
        run_frame(0, 0, 0, NPIX);
        drain();
        check("ramp_win_count", EW'(win_seen - w0), EW'(4));
        check("ramp_last_count", EW'(last_seen - l0), EW'(1));

        // Ramp frame, output stalled 5 cycles after the first window.
        w0 = win_seen; l0 = last_seen;
        fill_ramp();
        model_frame();
        run_frame(0, 0, 5, NPIX);
        drain();
        check("stall_win_count", EW'(win_seen - w0), EW'(4));
        check("stall_last_count", EW'(last_seen - l0), EW'(1));

        // Two random frames back-to-back with random gaps on both sides.
        w0 = win_seen; l0 = last_seen;
        fill_random();
        model_frame();
        run_frame(30, 30, 0, NPIX);
        fill_random();
        model_frame();
        run_frame(30, 30, 0, NPIX);
        drain();
        check("b2b_win_count", EW'(win_seen - w0), EW'(8));
        check("b2b_last_count", EW'(last_seen - l0), EW'(2));

        // Abort after 7 accepts, then a fresh frame.
        fill_ramp();
        run_frame(0, 0, 0, 7);
        do_reset();
        w0 = win_seen; l0 = last_seen;
        fill_random();
        model_frame();
        run_frame(0, 0, 0, NPIX);
        drain();
        check("rst7_win_count", EW'(win_seen - w0), EW'(4));
        check("rst7_last_count", EW'(last_seen - l0), EW'(1));

        // Abort with a window pending (out_ready low), then a fresh frame.
        fill_ramp();
        run_frame(0, 100, 0, 11);
        do_reset();
        w0 = win_seen;
        fill_random();
        model_frame();
        run_frame(20, 20, 0, NPIX);
        drain();
        check("rst11_win_count", EW'(win_seen - w0), EW'(4));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
